// File: rtl/stream_min.sv
// Frame-based running-minimum tracker: accepts LEN unsigned samples, then
// presents the smallest one and its position until the downstream takes it.
module stream_min #(
   parameter  int N   = 5,
   parameter  int LEN = 8,
   localparam int IW  = $clog2(LEN)
) (
   input  logic          clk_i,
   input  logic          rst_i,
   input  logic          clear_i,
   input  logic          in_valid_i,
   output logic          in_ready_o,
   input  logic [N-1:0]  in_data_i,
   output logic          out_valid_o,
   input  logic          out_ready_i,
   output logic [N-1:0]  out_min_o,
   output logic [IW-1:0] out_idx_o,
   output logic          dbg_state_o
);

   // Handshakes: a transfer happens on a rising edge where valid && ready;
   // a producer holds valid and its data stable until that edge.
   typedef enum logic {ACCUM = 1'b0, HOLD = 1'b1} state_t;

   localparam logic [IW-1:0] LAST = IW'(LEN - 1);

   state_t        state_q, state_d;
   logic [IW-1:0] count_q, count_d;
   logic [N-1:0]  min_q, min_d;
   logic [IW-1:0] idx_q, idx_d;
   logic [N-1:0]  omin_q, omin_d;
   logic [IW-1:0] oidx_q, oidx_d;
   logic          rdy_q;

   logic [N:0]    diff;
   logic          take_new;
   logic [N-1:0]  cand_min;
   logic [IW-1:0] cand_idx;
   logic          accept;

   // rdy_q keeps in_ready low while reset is held and for the release cycle.
   assign in_ready_o  = rdy_q && (state_q == ACCUM);
   assign out_valid_o = (state_q == HOLD);
   assign out_min_o   = omin_q;
   assign out_idx_o   = oidx_q;
   assign dbg_state_o = (state_q == HOLD);
   assign accept      = in_valid_i && in_ready_o;

   // Borrow out of the widened subtraction flags in_data < min_reg; ties keep
   // the earlier index.
   assign diff     = {1'b0, in_data_i} - {1'b0, min_q};
   assign take_new = (count_q == '0) || diff[N];
   assign cand_min = take_new ? in_data_i : min_q;
   assign cand_idx = take_new ? count_q : idx_q;

   always_comb begin
      state_d = state_q;
      count_d = count_q;
      min_d   = min_q;
      idx_d   = idx_q;
      omin_d  = omin_q;
      oidx_d  = oidx_q;
      if (clear_i) begin
         state_d = ACCUM;
         count_d = '0;
      end else begin
         case (state_q)
            ACCUM: begin
               if (accept) begin
                  min_d = cand_min;
                  idx_d = cand_idx;
                  if (count_q == LAST) begin
                     count_d = '0;
                     state_d = HOLD;
                     omin_d  = cand_min;
                     oidx_d  = cand_idx;
                  end else begin
                     count_d = count_q + 1'b1;
                  end
               end
            end
            HOLD: begin
               if (out_ready_i) state_d = ACCUM;
            end
            default: state_d = ACCUM;
         endcase
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q <= ACCUM;
         count_q <= '0;
         min_q   <= '0;
         idx_q   <= '0;
         omin_q  <= '0;
         oidx_q  <= '0;
         rdy_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         count_q <= count_d;
         min_q   <= min_d;
         idx_q   <= idx_d;
         omin_q  <= omin_d;
         oidx_q  <= oidx_d;
         rdy_q   <= 1'b1;
      end
   end

endmodule
